daq_stream_receiver: RTL and testbench

- Downstream consumer of the slave-DAQ output stream (SlaveDaqData/SlaveDaqData_en) and the AllDone/DataTransmitDone handshake.
- Forwards every data word to the USB output FIFO and parses the end-of-run tail sequence FF45 / CChh / llll / 45FF to recover the 24-bit trigger count.
- Completes the four-phase AllDone/DataTransmitDone handshake, so the DAQ controller can return to idle.
- Sits between the DAQ controller and the USB FIFO write port.

---
 rtl/daq_stream_receiver.sv | 196 +++++++++++++++++++
 tb/tb_daq_stream_receiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_stream_receiver.sv
// End-of-run consumer for the slave-DAQ stream: forwards words to the USB FIFO,
// recovers the trigger count from the FF45/CChh/llll/45FF tail and acknowledges AllDone.
//
// state  | meaning
// M_PAY  | payload, waiting for the tail head word
// M_HI   | head seen, expecting the tagged high-byte word
// M_LO   | high byte latched, next word is the low half
// M_END  | count complete, expecting the tail end word
// D_RUN  | run in progress, no AllDone pending
// D_WAIT | AllDone seen without a tail, timeout running
// D_ACK  | DataTransmitDone asserted until AllDone drops
module daq_stream_receiver #(
    parameter logic [15:0] DONE_TIMEOUT = 16'd1000,
    parameter logic [15:0] TAIL_HEAD    = 16'hFF45,
    parameter logic [15:0] TAIL_END     = 16'h45FF,
    parameter logic [7:0]  CNT_TAG      = 8'hCC
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [15:0] SlaveDaqData,
    input  logic        SlaveDaqData_en,
    input  logic        AllDone,
    output logic        DataTransmitDone,
    input  logic        ClearStatus,
    input  logic        UsbFifoFull,
    output logic [15:0] UsbData,
    output logic        UsbData_en,
    output logic [23:0] TrigCount,
    output logic        TrigCount_valid,
    output logic [15:0] WordCount,
    output logic        Overflow,
    output logic        TailMissing
);

    typedef enum logic [1:0] {M_PAY, M_HI, M_LO, M_END} match_t;
    typedef enum logic [1:0] {D_RUN, D_WAIT, D_ACK} hs_t;

    match_t      match_q, match_d;
    hs_t         hs_q, hs_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] timer_q, timer_d;
    logic        tail_seen_q, tail_seen_d;
    logic [15:0] usb_data_q, usb_data_d;
    logic        usb_en_q, usb_en_d;
    logic [23:0] trig_q, trig_d;
    logic        trig_valid_q, trig_valid_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic        overflow_q, overflow_d;
    logic        tail_missing_q, tail_missing_d;
    logic        dtd_q, dtd_d;

    logic        tail_done;
    logic        timeout;
    logic        run_end;
    logic [15:0] word_base;

    always_comb begin
        match_d   = match_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        tail_done = 1'b0;
        if (SlaveDaqData_en) begin
            case (match_q)
                M_PAY: begin
                    if (SlaveDaqData == TAIL_HEAD) match_d = M_HI;
                end
                M_HI: begin
                    if (SlaveDaqData[15:8] == CNT_TAG) begin
                        hi_d    = SlaveDaqData[7:0];
                        match_d = M_LO;
                    end else if (SlaveDaqData != TAIL_HEAD) begin
                        match_d = M_PAY;
                    end
                end
                M_LO: begin
                    lo_d    = SlaveDaqData;
                    match_d = M_END;
                end
                M_END: begin
                    if (SlaveDaqData == TAIL_END) begin
                        tail_done = 1'b1;
                        match_d   = M_PAY;
                    end else if (SlaveDaqData == TAIL_HEAD) begin
                        match_d = M_HI;
                    end else begin
                        match_d = M_PAY;
                    end
                end
                default: match_d = M_PAY;
            endcase
        end
        trig_d       = tail_done ? {hi_q, lo_q} : trig_q;
        trig_valid_d = tail_done;
    end

    always_comb begin
        hs_d    = hs_q;
        timer_d = timer_q;
        dtd_d   = dtd_q;
        timeout = 1'b0;
        run_end = 1'b0;
        case (hs_q)
            D_RUN: begin
                if (AllDone) begin
                    if (tail_seen_q || tail_done) begin
                        hs_d  = D_ACK;
                        dtd_d = 1'b1;
                    end else begin
                        hs_d    = D_WAIT;
                        timer_d = DONE_TIMEOUT - 16'd1;
                    end
                end
            end
            D_WAIT: begin
                if (!AllDone) begin
                    hs_d = D_RUN;
                end else if (tail_done) begin
                    hs_d  = D_ACK;
                    dtd_d = 1'b1;
                end else if (timer_q == 16'd0) begin
                    timeout = 1'b1;
                    hs_d    = D_ACK;
                    dtd_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            D_ACK: begin
                if (!AllDone) begin
                    hs_d    = D_RUN;
                    dtd_d   = 1'b0;
                    run_end = 1'b1;
                end
            end
            default: hs_d = D_RUN;
        endcase
    end

    // A word or tail arriving in the closing cycle of the handshake belongs to the next run.
    always_comb begin
        usb_en_d       = SlaveDaqData_en && !UsbFifoFull;
        usb_data_d     = usb_en_d ? SlaveDaqData : usb_data_q;
        overflow_d     = (SlaveDaqData_en && UsbFifoFull) ? 1'b1 :
                         (ClearStatus ? 1'b0 : overflow_q);
        tail_missing_d = timeout ? 1'b1 : (ClearStatus ? 1'b0 : tail_missing_q);
        tail_seen_d    = tail_done ? 1'b1 : (run_end ? 1'b0 : tail_seen_q);
        word_base      = run_end ? 16'd0 : word_cnt_q;
        word_cnt_d     = word_base;
        if (SlaveDaqData_en && (word_base != 16'hFFFF)) word_cnt_d = word_base + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            match_q        <= M_PAY;
            hs_q           <= D_RUN;
            hi_q           <= 8'd0;
            lo_q           <= 16'd0;
            timer_q        <= 16'd0;
            tail_seen_q    <= 1'b0;
            usb_data_q     <= 16'd0;
            usb_en_q       <= 1'b0;
            trig_q         <= 24'd0;
            trig_valid_q   <= 1'b0;
            word_cnt_q     <= 16'd0;
            overflow_q     <= 1'b0;
            tail_missing_q <= 1'b0;
            dtd_q          <= 1'b0;
        end else begin
            match_q        <= match_d;
            hs_q           <= hs_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            timer_q        <= timer_d;
            tail_seen_q    <= tail_seen_d;
            usb_data_q     <= usb_data_d;
            usb_en_q       <= usb_en_d;
            trig_q         <= trig_d;
            trig_valid_q   <= trig_valid_d;
            word_cnt_q     <= word_cnt_d;
            overflow_q     <= overflow_d;
            tail_missing_q <= tail_missing_d;
            dtd_q          <= dtd_d;
        end
    end

    assign UsbData          = usb_data_q;
    assign UsbData_en       = usb_en_q;
    assign TrigCount        = trig_q;
    assign TrigCount_valid  = trig_valid_q;
    assign WordCount        = word_cnt_q;
    assign Overflow         = overflow_q;
    assign TailMissing      = tail_missing_q;
    assign DataTransmitDone = dtd_q;

endmodule

// File: tb/tb_daq_stream_receiver.sv
// Scoreboard bench for daq_stream_receiver: a tail parser over a word queue predicts
// forwarded words, trigger-count pulses, counters, flags and handshake timing.
module tb_daq_stream_receiver;

    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] SlaveDaqData;
    logic        SlaveDaqData_en;
    logic        AllDone;
    logic        DataTransmitDone;
    logic        ClearStatus;
    logic        UsbFifoFull;
    logic [15:0] UsbData;
    logic        UsbData_en;
    logic [23:0] TrigCount;
    logic        TrigCount_valid;
    logic [15:0] WordCount;
    logic        Overflow;
    logic        TailMissing;

    daq_stream_receiver dut (
        .Clk(clk), .reset(reset),
        .SlaveDaqData(SlaveDaqData), .SlaveDaqData_en(SlaveDaqData_en),
        .AllDone(AllDone), .DataTransmitDone(DataTransmitDone),
        .ClearStatus(ClearStatus), .UsbFifoFull(UsbFifoFull),
        .UsbData(UsbData), .UsbData_en(UsbData_en),
        .TrigCount(TrigCount), .TrigCount_valid(TrigCount_valid),
        .WordCount(WordCount), .Overflow(Overflow), .TailMissing(TailMissing)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_on = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [15:0] data; int at; } usb_exp_t;
    typedef struct { logic [23:0] val;  int at; } trig_exp_t;
    usb_exp_t  usb_q[$];
    trig_exp_t trig_q[$];

    // reference model state
    logic [15:0] cand[$];
    int          m_wc;
    bit          m_ovf, m_tmiss, m_seen;
    logic [23:0] m_trig;

    logic [15:0] s_basic[6] = '{16'h1234, 16'hABCD, 16'hFF45, 16'hCC12, 16'h3456, 16'h45FF};
    logic [15:0] s_fake[6]  = '{16'hFF45, 16'h0001, 16'hFF45, 16'hCC00, 16'h0007, 16'h45FF};
    logic [15:0] s_bad[4]   = '{16'hFF45, 16'hCD00, 16'h0007, 16'h45FF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%h required=none", name, act);
    endtask

    task automatic model_word(input logic [15:0] w, input bit full);
        logic [23:0] v;
        if (!full) usb_q.push_back('{w, cyc + 1});
        if (m_wc < 65535) m_wc++;
        case (cand.size())
            0: if (w == 16'hFF45) cand.push_back(w);
            1: begin
                if (w[15:8] == 8'hCC) cand.push_back(w);
                else if (w != 16'hFF45) cand.delete();
            end
            2: cand.push_back(w);
            default: begin
                if (w == 16'h45FF) begin
                    v = {cand[1][7:0], cand[2]};
                    trig_q.push_back('{v, cyc + 1});
                    m_trig = v;
                    m_seen = 1'b1;
                    cand.delete();
                end else begin
                    cand.delete();
                    if (w == 16'hFF45) cand.push_back(w);
                end
            end
        endcase
    endtask

    // called at a negedge; returns at the following negedge with inputs idle
    task automatic drive(input bit en, input logic [15:0] w, input bit full, input bit clr);
        SlaveDaqData_en = en;
        SlaveDaqData    = w;
        UsbFifoFull     = full;
        ClearStatus     = clr;
        if (en) model_word(w, full);
        if (en && full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_tmiss = 1'b0;
        @(negedge clk);
        SlaveDaqData_en = 1'b0;
        UsbFifoFull     = 1'b0;
        ClearStatus     = 1'b0;
    endtask

    task automatic send(input logic [15:0] w);
        drive(1'b1, w, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        cand.delete();
        m_wc = 0; m_ovf = 0; m_tmiss = 0; m_seen = 0; m_trig = 24'd0;
        @(negedge clk);
        chk("rst_usbdata", UsbData, 16'd0);
        chk("rst_usben", UsbData_en, 1'b0);
        chk("rst_trig", TrigCount, 24'd0);
        chk("rst_trigvalid", TrigCount_valid, 1'b0);
        chk("rst_wordcount", WordCount, 16'd0);
        chk("rst_overflow", Overflow, 1'b0);
        chk("rst_tailmissing", TailMissing, 1'b0);
        chk("rst_dtd", DataTransmitDone, 1'b0);
        reset = 1'b0;
    endtask

    task automatic handshake(input bit with_word, input logic [15:0] w);
        int n;
        bit exp_tmo;
        n = 0;
        AllDone = 1'b1;
        if (with_word) begin
            SlaveDaqData_en = 1'b1;
            SlaveDaqData    = w;
            model_word(w, 1'b0);
        end
        exp_tmo = !m_seen;
        do begin
            @(negedge clk);
            SlaveDaqData_en = 1'b0;
            n++;
        end while (DataTransmitDone !== 1'b1 && n < TMO + 20);
        chk("dtd_rise_cycles", n, exp_tmo ? TMO + 1 : 1);
        if (exp_tmo) m_tmiss = 1'b1;
        chk("tail_missing", TailMissing, m_tmiss);
        chk("wordcount_ack", WordCount, m_wc);
        repeat (3) @(negedge clk);
        chk("dtd_held", DataTransmitDone, 1'b1);
        AllDone = 1'b0;
        @(negedge clk);
        chk("dtd_fall", DataTransmitDone, 1'b0);
        chk("wordcount_clr", WordCount, 16'd0);
        m_wc = 0;
        m_seen = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (UsbData_en === 1'b1) begin
                if (usb_q.size() == 0) fail_now("usb_unexpected", UsbData);
                else begin
                    usb_exp_t e;
                    e = usb_q.pop_front();
                    chk("usb_data", UsbData, e.data);
                    chk("usb_latency", cyc, e.at);
                end
            end else if (usb_q.size() != 0 && usb_q[0].at <= cyc) begin
                fail_now("usb_missing", usb_q[0].data);
                void'(usb_q.pop_front());
            end
            if (TrigCount_valid === 1'b1) begin
                if (trig_q.size() == 0) fail_now("trig_unexpected", TrigCount);
                else begin
                    trig_exp_t t;
                    t = trig_q.pop_front();
                    chk("trig_value", TrigCount, t.val);
                    chk("trig_latency", cyc, t.at);
                end
            end else if (trig_q.size() != 0 && trig_q[0].at <= cyc) begin
                fail_now("trig_missing", trig_q[0].val);
                void'(trig_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; SlaveDaqData = 16'd0; SlaveDaqData_en = 1'b0;
        AllDone = 1'b0; ClearStatus = 1'b0; UsbFifoFull = 1'b0;
        @(negedge clk);
        reset_dut();
        mon_on = 1'b1;

        foreach (s_basic[i]) send(s_basic[i]);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("basic_trig", TrigCount, m_trig);
        chk("basic_wordcount", WordCount, m_wc);
        handshake(1'b0, 16'd0);

        foreach (s_fake[i]) send(s_fake[i]);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("fake_head_trig", TrigCount, m_trig);
        handshake(1'b0, 16'd0);

        foreach (s_bad[i]) send(s_bad[i]);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("bad_tag_trig", TrigCount, m_trig);
        handshake(1'b0, 16'd0);

        send(16'hFF45);
        drive(1'b1, 16'hCC00, 1'b1, 1'b0);
        send(16'h0007);
        send(16'h45FF);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("drop_overflow", Overflow, m_ovf);
        chk("drop_trig", TrigCount, m_trig);
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        chk("clear_overflow", Overflow, m_ovf);
        chk("clear_tailmissing", TailMissing, m_tmiss);
        drive(1'b1, 16'h5555, 1'b1, 1'b1);
        chk("set_wins_overflow", Overflow, m_ovf);
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        handshake(1'b0, 16'd0);

        send(16'hFF45);
        send(16'hCC01);
        send(16'h0203);
        handshake(1'b1, 16'h45FF);

        send(16'hFF45);
        send(16'hCC12);
        reset_dut();
        send(16'h3456);
        send(16'h45FF);
        repeat (2) drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("post_reset_trig", TrigCount, m_trig);

        for (int k = 0; k < 400; k++) begin
            logic [15:0] w;
            int r;
            r = $urandom_range(0, 7);
            case (r)
                0: w = 16'hFF45;
                1: w = 16'h45FF;
                2: w = {8'hCC, 8'($urandom)};
                default: w = 16'($urandom);
            endcase
            drive(($urandom % 4) != 0, w, ($urandom % 10) == 0, ($urandom % 25) == 0);
            chk("rand_overflow", Overflow, m_ovf);
            chk("rand_wordcount", WordCount, m_wc);
            chk("rand_tailmissing", TailMissing, m_tmiss);
        end
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("rand_trig", TrigCount, m_trig);
        handshake(1'b0, 16'd0);

        repeat (3) @(negedge clk);
        chk("usb_queue_drained", usb_q.size(), 0);
        chk("trig_queue_drained", trig_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
